hscale_pipelined: RTL
=====================

HSCALE_PIPELINED -- requirements
Module: hscale_pipelined

Interface
REQ-001 SHALL have parameter IN_W, default 17, meaning input sample width (matches upstream adder output width).
REQ-002 SHALL have parameter OUT_W, default 16, meaning output sample width (fixed-point total width).
REQ-003 SHALL have parameter FRAC, default 14, meaning coefficient fractional bits.
REQ-004 SHALL have parameter COEF, default 11585, meaning 1/sqrt(2) in signed Q1.FRAC.
REQ-005 SHALL have port clk  input  1  clock, all logic on rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port in_valid  input  1  input sample present.
REQ-008 SHALL have port in_ready  output  1  block accepts input this cycle.
REQ-009 SHALL have ports xr, xi  input  IN_W each  signed complex input sample.
REQ-010 SHALL have port out_valid  output  1  output sample present.
REQ-011 SHALL have port out_ready  input  1  downstream accepts output this cycle.
REQ-012 SHALL have ports yr, yi  output  OUT_W each  signed scaled complex output.
REQ-013 SHALL have port out_sat  output  1  either component of current output saturated.
REQ-014 SHALL have port sat_clr  input  1  synchronous clear of sat_count.
REQ-015 SHALL have port sat_count  output  16  count of saturated samples delivered.

Function
REQ-016 SHALL be a 3-stage pipeline: S1 input register, S2 signed multiply by COEF, S3 round/saturate register driving outputs; latency 3 cycles from accepted input to out_valid with no stall.
REQ-017 SHALL carry one valid bit per stage; a transfer in occurs when in_valid && in_ready, a transfer out when out_valid && out_ready.
REQ-018 SHALL compute stall = out_valid && !out_ready; in_ready = !stall, combinational, no dependency on in_valid.
REQ-019 SHALL hold all stage data and valid bits unchanged while stall is high; otherwise every stage advances, with S1 valid loaded from in_valid.
REQ-020 SHALL advance bubbles like data; no bubble collapsing is required.
REQ-021 SHALL form S2 product p = x * COEF at full width (IN_W+16 bits, signed), per component.
REQ-022 SHALL round as y_full = floor((p + 2^(FRAC-1)) / 2^FRAC) (add half, arithmetic shift right).
REQ-023 SHALL saturate y_full to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; out_sat = 1 if either component was clamped.
REQ-024 SHALL keep yr, yi, out_sat registered and stable while out_valid && !out_ready.
REQ-025 SHALL increment sat_count by 1 on each transfer out with out_sat = 1, saturating at 65535 (no wrap).
REQ-026 SHALL give sat_clr priority over increment in the same cycle (result 0).
REQ-027 SHALL treat real and imaginary paths identically and in lockstep.

Reset
REQ-028 SHALL, on rst = 1 at a rising edge, clear all valid bits, yr, yi, out_sat, sat_count and stage data to 0.
REQ-029 SHALL drive in_ready = 1 during and immediately after reset (out_valid = 0).
REQ-030 SHALL discard in-flight samples on reset mid-operation; no output for them appears afterwards.
REQ-031 SHALL give rst priority over sat_clr, stall and input transfer.

Verification
REQ-032 Rounding: xr=16384, xi=-16384, out_ready=1 -> 3 cycles later yr=11585, yi=-11585, out_sat=0; xr=1, xi=0 -> yr=1, yi=0.
REQ-033 Saturation: xr=65535, xi=-65536 -> yr=32767, yi=-32768, out_sat=1, sat_count 0->1 on transfer.
REQ-034 Back-pressure: stream 6 samples at in_valid=1, hold out_ready=0 from cycle 4 for 5 cycles -> in_ready=0 during stall, outputs frozen, all 6 samples delivered in order, none lost or duplicated.
REQ-035 Counter: 65537 saturating transfers -> sat_count=65535; sat_clr asserted with a saturating transfer -> sat_count=0.
REQ-036 Reset mid-stream: rst=1 for one cycle with 3 samples in flight -> next cycle out_valid=0, sat_count=0, in_ready=1; no stale sample ever emitted.

Source files
------------

// File: rtl/hscale_pipelined.sv
// hscale_pipelined: scales a signed complex sample by COEF (1/sqrt(2) by
// default) through a 3-stage pipeline with valid/ready flow control.
//   S1 registers the input, S2 registers the full-width product, and S3
//   registers the rounded and saturated result that drives the outputs.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   input handshake (in_ready = !stall)
//   xr, xi              signed IN_W complex input
//   out_valid/out_ready output handshake
//   yr, yi              signed OUT_W complex output
//   out_sat             either component of the current output clamped
//   sat_clr             synchronous clear of sat_count
//   sat_count           saturating count of clamped samples delivered

// One datapath lane (real or imaginary); both lanes share the same enable,
// so the two components always stay in lockstep.
module hscale_lane #(
    parameter int IN_W  = 17,
    parameter int OUT_W = 16,
    parameter int FRAC  = 14,
    parameter int COEF  = 11585
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic signed [IN_W-1:0]  x,
    output logic signed [OUT_W-1:0] y,
    output logic                    sat
);
    localparam int PW = IN_W + 16;
    localparam int RW = PW - FRAC + 1;
    localparam logic signed [15:0]   C    = 16'(COEF);
    localparam logic signed [PW:0]   HALF = {{(PW+1-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};
    localparam logic signed [RW-1:0] YMAX = {{(RW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [RW-1:0] YMIN = {{(RW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    logic signed [IN_W-1:0]  s1_x;
    logic signed [PW-1:0]    s2_p;
    logic signed [PW-1:0]    p;
    logic signed [PW:0]      rnd_sum;
    logic signed [RW-1:0]    y_full;
    logic signed [OUT_W-1:0] y_sat;
    logic                    ovf;

    assign p = $signed({{16{s1_x[IN_W-1]}}, s1_x}) * $signed({{IN_W{C[15]}}, C});

    // One extra bit so adding the half LSB can never overflow; the
    // arithmetic shift is a plain slice of the widened sum.
    assign rnd_sum = $signed({s2_p[PW-1], s2_p}) + HALF;
    assign y_full  = rnd_sum[PW:FRAC];

    always_comb begin
        y_sat = y_full[OUT_W-1:0];
        ovf   = 1'b0;
        if (y_full > YMAX) begin
            y_sat = YMAX[OUT_W-1:0];
            ovf   = 1'b1;
        end else if (y_full < YMIN) begin
            y_sat = YMIN[OUT_W-1:0];
            ovf   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_x <= '0;
            s2_p <= '0;
            y    <= '0;
            sat  <= 1'b0;
        end else if (en) begin
            s1_x <= x;
            s2_p <= p;
            y    <= y_sat;
            sat  <= ovf;
        end
    end
endmodule

module hscale_pipelined #(
    parameter int IN_W  = 17,
    parameter int OUT_W = 16,
    parameter int FRAC  = 14,
    parameter int COEF  = 11585
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [IN_W-1:0]  xr,
    input  logic signed [IN_W-1:0]  xi,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] yr,
    output logic signed [OUT_W-1:0] yi,
    output logic                    out_sat,
    input  logic                    sat_clr,
    output logic [15:0]             sat_count
);
    localparam int STAGES = 3;
    localparam int NUM_LANES = 2;

    // vld_pipe[0] = S1 ... vld_pipe[STAGES-1] = S3 (drives out_valid)
    logic [STAGES-1:0]                vld_pipe;
    logic                             stall;
    logic [NUM_LANES-1:0][IN_W-1:0]   lane_x;
    logic [NUM_LANES-1:0][OUT_W-1:0]  lane_y;
    logic [NUM_LANES-1:0]             lane_sat;

    assign out_valid = vld_pipe[STAGES-1];
    assign stall     = out_valid && !out_ready;
    assign in_ready  = !stall;

    // Bubbles advance like data; the whole pipe freezes on stall.
    always_ff @(posedge clk) begin
        if (rst)
            vld_pipe <= '0;
        else if (!stall)
            vld_pipe <= {vld_pipe[STAGES-2:0], in_valid};
    end

    assign lane_x = {xi, xr};

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        hscale_lane #(.IN_W(IN_W), .OUT_W(OUT_W), .FRAC(FRAC), .COEF(COEF)) u_lane (
            .clk (clk),
            .rst (rst),
            .en  (!stall),
            .x   (lane_x[g]),
            .y   (lane_y[g]),
            .sat (lane_sat[g])
        );
    end

    assign yr      = lane_y[0];
    assign yi      = lane_y[1];
    assign out_sat = |lane_sat;

    always_ff @(posedge clk) begin
        if (rst || sat_clr)
            sat_count <= '0;
        else if (out_valid && out_ready && out_sat && sat_count != 16'hFFFF)
            sat_count <= sat_count + 16'd1;
    end
endmodule
